ssd_scan_driver: RTL and testbench

Drives the board's 4-digit, active-low seven-segment display from the 13-bit value selected by the debug display mux. It converts the binary value to four BCD digits with a sequential double-dabble converter, then time-multiplexes the digits onto the shared segment bus. It sits between the display-select mux output and the FPGA pins.

---
 rtl/ssd_pkg.sv | 47 ++++
 rtl/bin2bcd_seq.sv | 85 ++++++++
 rtl/ssd_scan_driver.sv | 92 +++++++++
 tb/tb_ssd_scan_driver.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared constants, converter state encoding and segment helpers for the
// four-digit seven-segment scan driver.
package ssd_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DATA_W     = 13;
    localparam int BCD_W      = 4 * NUM_DIGITS;
    localparam int BITCNT_W   = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    // Active-low {g,f,e,d,c,b,a}; non-decimal codes fall back to a dark digit.
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] r_code;
        case (digit)
            4'd0:    r_code = 7'b1000000;
            4'd1:    r_code = 7'b1111001;
            4'd2:    r_code = 7'b0100100;
            4'd3:    r_code = 7'b0110000;
            4'd4:    r_code = 7'b0011001;
            4'd5:    r_code = 7'b0010010;
            4'd6:    r_code = 7'b0000010;
            4'd7:    r_code = 7'b1111000;
            4'd8:    r_code = 7'b0000000;
            4'd9:    r_code = 7'b0010000;
            default: r_code = SEG_BLANK;
        endcase
        return r_code;
    endfunction

    function automatic logic [3:0] bcd_adjust(input logic [3:0] nibble);
        logic [3:0] r_adj;
        if (nibble >= 4'd5) begin
            r_adj = nibble + 4'd3;
        end else begin
            r_adj = nibble;
        end
        return r_adj;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, re-converts whenever
// the input differs from the last value it finished converting.
module bin2bcd_seq
    import ssd_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_value,
    output logic [BCD_W-1:0]  o_digits,
    output logic              o_busy
);

    conv_state_t          r_state;
    logic [DATA_W-1:0]    r_bin;
    logic [DATA_W-1:0]    r_conv;
    logic [DATA_W-1:0]    r_last_value;
    logic [BCD_W-1:0]     r_bcd;
    logic [BCD_W-1:0]     r_digits;
    logic [BITCNT_W-1:0]  r_bit_cnt;
    logic                 r_busy;
    logic [BCD_W-1:0]     w_bcd_adj;

    // Add-3 correction on every nibble ahead of the shift.
    always_comb begin
        w_bcd_adj = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_bcd_adj[4*i +: 4] = bcd_adjust(r_bcd[4*i +: 4]);
        end
    end

    // Converter FSM; r_conv keeps the value that is actually being shifted so
    // that later input changes cannot corrupt last_value.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_bin        <= '0;
            r_conv       <= '0;
            r_last_value <= '0;
            r_bcd        <= '0;
            r_digits     <= '0;
            r_bit_cnt    <= '0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_value != r_last_value) begin
                        r_bin     <= i_value;
                        r_conv    <= i_value;
                        r_bcd     <= '0;
                        r_bit_cnt <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= SHIFT;
                    end else begin
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                SHIFT: begin
                    r_bcd     <= {w_bcd_adj[BCD_W-2:0], r_bin[DATA_W-1]};
                    r_bin     <= {r_bin[DATA_W-2:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                    if (r_bit_cnt == BITCNT_W'(DATA_W - 1)) begin
                        r_state <= DONE;
                    end else begin
                        r_state <= SHIFT;
                    end
                end
                DONE: begin
                    r_digits     <= r_bcd;
                    r_last_value <= r_conv;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_digits = r_digits;
    assign o_busy   = r_busy;

endmodule

// File: rtl/ssd_scan_driver.sv
// Four-digit active-low seven-segment scan driver fed by a sequential BCD
// converter. Optional macro SSD_LEADING_ZERO_BLANK_EN blanks leading zeros.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     value,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [6:0]            seg,
    output logic                  busy
);

    localparam int              CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0]      r_refresh_cnt;
    logic [1:0]            r_digit_idx;
    logic [NUM_DIGITS-1:0] r_anode;
    logic [6:0]            r_seg;

    logic [BCD_W-1:0]      w_digits;
    logic                  w_busy;
    logic                  w_wrap;
    logic [1:0]            w_idx_next;
    logic [3:0]            w_digit_sel;
    logic                  w_blank;
    logic [6:0]            w_seg_next;
    logic [NUM_DIGITS-1:0] w_anode_next;

    bin2bcd_seq u_conv (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_value  (value),
        .o_digits (w_digits),
        .o_busy   (w_busy)
    );

    // Next-slot selection; anode and seg are both derived from the next index
    // so they always switch together on the same edge.
    always_comb begin
        w_wrap       = (r_refresh_cnt == CNT_MAX);
        if (w_wrap) begin
            w_idx_next = r_digit_idx + 2'd1;
        end else begin
            w_idx_next = r_digit_idx;
        end
        w_digit_sel  = w_digits[4*w_idx_next +: 4];
        w_anode_next = ~(4'b0001 << w_idx_next);
`ifdef SSD_LEADING_ZERO_BLANK_EN
        case (w_idx_next)
            2'd1:    w_blank = (w_digits[15:4]  == 12'd0);
            2'd2:    w_blank = (w_digits[15:8]  == 8'd0);
            2'd3:    w_blank = (w_digits[15:12] == 4'd0);
            default: w_blank = 1'b0;
        endcase
`else
        w_blank = 1'b0;
`endif
        if (w_blank) begin
            w_seg_next = SEG_BLANK;
        end else begin
            w_seg_next = seg_encode(w_digit_sel);
        end
    end

    // Refresh counter, digit index and registered pin drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh_cnt <= '0;
            r_digit_idx   <= 2'd0;
            r_anode       <= 4'b1110;
            r_seg         <= 7'b1000000;
        end else begin
            if (w_wrap) begin
                r_refresh_cnt <= '0;
            end else begin
                r_refresh_cnt <= r_refresh_cnt + CNT_W'(1);
            end
            r_digit_idx <= w_idx_next;
            r_anode     <= w_anode_next;
            r_seg       <= w_seg_next;
        end
    end

    assign anode = r_anode;
    assign seg   = r_seg;
    assign busy  = w_busy;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed self-checking bench for ssd_scan_driver (REFRESH_DIV=4 and 2 instances).
module tb_ssd_scan_driver;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic [12:0] value_a, value_b;
    logic [3:0]  anode_a, anode_b;
    logic [6:0]  seg_a, seg_b;
    logic        busy_a, busy_b;

    int checks = 0;
    int errors = 0;

`ifdef SSD_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LEAD = 7'b1111111;
`else
    localparam logic [6:0] LEAD = 7'b1000000;
`endif

    always #5 clk = ~clk;

    ssd_scan_driver #(.REFRESH_DIV(4)) dut_a (
        .clk(clk), .rst(rst_a), .value(value_a),
        .anode(anode_a), .seg(seg_a), .busy(busy_a)
    );

    ssd_scan_driver #(.REFRESH_DIV(2)) dut_b (
        .clk(clk), .rst(rst_b), .value(value_b),
        .anode(anode_b), .seg(seg_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy_a && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, {31'd0, busy_a}, 32'd0);
    endtask

    // Align to the start of the ones-digit slot, then check one full scan.
    task automatic scan_check(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
        logic [6:0] exp_seg [4];
        logic [3:0] prev;
        logic [3:0] exp_an;
        int         n;
        bit         found;
        exp_seg[0] = s0;
        exp_seg[1] = s1;
        exp_seg[2] = s2;
        exp_seg[3] = s3;
        found = 1'b0;
        n = 0;
        while (!found && n < 20) begin
            prev = anode_a;
            tick();
            n++;
            if (anode_a == 4'b1110 && prev != 4'b1110) found = 1'b1;
        end
        check({tag, "_sync"}, {31'd0, found}, 32'd1);
        for (int c = 0; c < 16; c++) begin
            exp_an = 4'hF ^ (4'h1 << (c / 4));
            check({tag, "_anode"}, {28'd0, anode_a}, {28'd0, exp_an});
            check({tag, "_seg"}, {25'd0, seg_a}, {25'd0, exp_seg[c / 4]});
            tick();
        end
        check({tag, "_wrap"}, {28'd0, anode_a}, 32'he);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [3:0] exp_an;

        rst_a = 1'b1; rst_b = 1'b1; value_a = 13'd0; value_b = 13'd0;
        tick(); tick();
        check("rst_anode", {28'd0, anode_a}, 32'he);
        check("rst_seg", {25'd0, seg_a}, 32'h40);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        rst_a = 1'b0; rst_b = 1'b0;

        // Scan wrap at REFRESH_DIV=2: after release edge k the index is (k/2)%4.
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp_an = 4'hF ^ (4'h1 << ((k / 2) % 4));
            check("scanb_anode", {28'd0, anode_b}, {28'd0, exp_an});
            check("scanb_onecold", $countones(~anode_b), 32'd1);
            check("scanb_seg", {25'd0, seg_b}, 32'h40);
        end
        check("zero_no_conv", {31'd0, busy_a}, 32'd0);

        // Full scale 8191: busy exactly 14 cycles.
        value_a = 13'd8191;
        tick();
        check("fs_busy_start", {31'd0, busy_a}, 32'd1);
        n = 1;
        while (n < 40) begin
            tick();
            if (!busy_a) break;
            n++;
        end
        check("fs_busy_len", n, 32'd14);
        check("fs_digits", {16'd0, dut_a.w_digits}, 32'h8191);
        scan_check("fs", 7'b1111001, 7'b0010000, 7'b1111001, 7'b0000000);

        // Mid-conversion change: 1234 then 42.
        value_a = 13'd1234;
        tick();
        check("mid_busy", {31'd0, busy_a}, 32'd1);
        repeat (4) tick();
        value_a = 13'd42;
        repeat (9) tick();
        check("mid_hold", {16'd0, dut_a.w_digits}, 32'h8191);
        tick();
        check("mid_first", {16'd0, dut_a.w_digits}, 32'h1234);
        check("mid_first_busy", {31'd0, busy_a}, 32'd0);
        tick();
        check("mid_restart", {31'd0, busy_a}, 32'd1);
        repeat (13) tick();
        check("mid_hold2", {16'd0, dut_a.w_digits}, 32'h1234);
        tick();
        check("mid_second", {16'd0, dut_a.w_digits}, 32'h0042);
        check("mid_second_busy", {31'd0, busy_a}, 32'd0);

        // Leading-zero handling with value 7.
        value_a = 13'd7;
        tick();
        check("lz_busy", {31'd0, busy_a}, 32'd1);
        wait_idle("lz");
        check("lz_digits", {16'd0, dut_a.w_digits}, 32'h0007);
        scan_check("lz", 7'b1111000, LEAD, LEAD, LEAD);

        // Reset in the middle of converting 5555.
        value_a = 13'd5555;
        tick();
        repeat (5) tick();
        check("rm_busy_pre", {31'd0, busy_a}, 32'd1);
        rst_a = 1'b1;
        tick();
        check("rm_busy", {31'd0, busy_a}, 32'd0);
        check("rm_digits", {16'd0, dut_a.w_digits}, 32'h0);
        check("rm_anode", {28'd0, anode_a}, 32'he);
        check("rm_seg", {25'd0, seg_a}, 32'h40);
        rst_a = 1'b0;
        repeat (14) tick();
        check("rm_busy_run", {31'd0, busy_a}, 32'd1);
        check("rm_digits_run", {16'd0, dut_a.w_digits}, 32'h0);
        tick();
        check("rm_digits_done", {16'd0, dut_a.w_digits}, 32'h5555);
        check("rm_busy_done", {31'd0, busy_a}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
